// File: rtl/mem_miss_arbiter.sv
// Shared miss/refill controller: round-robin picks a missing cache port, writes back a dirty victim, then fills the line.
// Optional per-port fill/writeback counters are built only when MISS_CNT_EN is defined.
module mem_miss_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 14,
    parameter int LINE_W    = 64,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]        wb_req_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] victim_addr_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] fill_addr_i,
    input  logic [NUM_PORTS*LINE_W-1:0] wb_data_i,
    output logic [NUM_PORTS-1:0]        grant_o,
    output logic [NUM_PORTS-1:0]        done_o,
    output logic [LINE_W-1:0]           fill_data_o,
    output logic                        busy_o,
    output logic                        m_re_o,
    output logic                        m_we_o,
    output logic [ADDR_W-1:0]           m_addr_o,
    output logic [LINE_W-1:0]           m_wdata_o,
    input  logic [LINE_W-1:0]           m_rdata_i,
`ifdef MISS_CNT_EN
    output logic [NUM_PORTS*CNT_W-1:0]  miss_cnt_o,
    output logic [NUM_PORTS*CNT_W-1:0]  wb_cnt_o,
`endif
    input  logic                        m_rdy_i
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       rr_q;
    logic [IDX_W-1:0]       win_q;
    logic [NUM_PORTS-1:0]   mask_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [NUM_PORTS-1:0]   done_q;
    logic [ADDR_W-1:0]      fill_addr_q;
    logic [LINE_W-1:0]      fill_data_q;
    logic                   busy_q;
    logic                   m_re_q;
    logic                   m_we_q;
    logic [ADDR_W-1:0]      m_addr_q;
    logic [LINE_W-1:0]      m_wdata_q;

    logic [NUM_PORTS-1:0]   elig_d;
    logic [NUM_PORTS-1:0]   win_oh_d;
    logic [IDX_W-1:0]       win_idx_d;
    logic                   win_vld_d;

    // Walk offsets from the far end back toward rr_q so the nearest eligible port wins.
    always_comb begin
        elig_d    = req_i & ~mask_q;
        win_vld_d = 1'b0;
        win_idx_d = '0;
        win_oh_d  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (elig_d[(int'(rr_q) + k) % NUM_PORTS]) begin
                win_vld_d = 1'b1;
                win_idx_d = IDX_W'((int'(rr_q) + k) % NUM_PORTS);
                win_oh_d  = '0;
                win_oh_d[(int'(rr_q) + k) % NUM_PORTS] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            mask_q      <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            busy_q      <= 1'b0;
            m_re_q      <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            done_q <= '0;
            mask_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        win_q       <= win_idx_d;
                        grant_q     <= win_oh_d;
                        busy_q      <= 1'b1;
                        fill_addr_q <= fill_addr_i[win_idx_d*ADDR_W +: ADDR_W];
                        if (wb_req_i[win_idx_d]) begin
                            state_q   <= WB;
                            m_we_q    <= 1'b1;
                            m_addr_q  <= victim_addr_i[win_idx_d*ADDR_W +: ADDR_W];
                            m_wdata_q <= wb_data_i[win_idx_d*LINE_W +: LINE_W];
                        end else begin
                            state_q  <= FILL;
                            m_re_q   <= 1'b1;
                            m_addr_q <= fill_addr_i[win_idx_d*ADDR_W +: ADDR_W];
                        end
                    end
                end
                WB: begin
                    if (m_rdy_i) begin
                        state_q  <= FILL;
                        m_we_q   <= 1'b0;
                        m_re_q   <= 1'b1;
                        m_addr_q <= fill_addr_q;
                    end
                end
                FILL: begin
                    if (m_rdy_i) begin
                        state_q     <= DONE;
                        m_re_q      <= 1'b0;
                        fill_data_q <= m_rdata_i;
                        done_q      <= grant_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    rr_q    <= (int'(win_q) == NUM_PORTS - 1) ? '0 : win_q + 1'b1;
                    mask_q  <= grant_q;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign fill_data_o = fill_data_q;
    assign busy_o      = busy_q;
    assign m_re_o      = m_re_q;
    assign m_we_o      = m_we_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdata_o   = m_wdata_q;

`ifdef MISS_CNT_EN
    logic [NUM_PORTS*CNT_W-1:0] miss_cnt_q;
    logic [NUM_PORTS*CNT_W-1:0] wb_cnt_q;

    // Counts land on the same edge that completes the memory op, so miss_cnt moves with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (state_q == FILL && m_rdy_i &&
                miss_cnt_q[win_q*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                miss_cnt_q[win_q*CNT_W +: CNT_W] <= miss_cnt_q[win_q*CNT_W +: CNT_W] + 1'b1;
            end
            if (state_q == WB && m_rdy_i &&
                wb_cnt_q[win_q*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                wb_cnt_q[win_q*CNT_W +: CNT_W] <= wb_cnt_q[win_q*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end

    assign miss_cnt_o = miss_cnt_q;
    assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed bench for mem_miss_arbiter: table of single-port misses plus hand sequences for arbitration, reset and stray strobes.
module tb_mem_miss_arbiter;

    localparam int NP = 2;
    localparam int AW = 14;
    localparam int LW = 64;
    localparam int CW = 2;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     req;
    logic [NP-1:0]     wb_req;
    logic [NP*AW-1:0]  victim;
    logic [NP*AW-1:0]  fill;
    logic [NP*LW-1:0]  wbdata;
    logic [NP-1:0]     grant;
    logic [NP-1:0]     done;
    logic [LW-1:0]     fill_data;
    logic              busy;
    logic              m_re;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [LW-1:0]     m_wdata;
    logic [LW-1:0]     m_rdata;
    logic              m_rdy;
    logic              mdl_rdy;
    logic              stray_rdy;
`ifdef MISS_CNT_EN
    logic [NP*CW-1:0]  miss_cnt;
    logic [NP*CW-1:0]  wb_cnt;
`endif

    assign m_rdy = mdl_rdy | stray_rdy;

    mem_miss_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_i(req), .wb_req_i(wb_req),
        .victim_addr_i(victim), .fill_addr_i(fill), .wb_data_i(wbdata),
        .grant_o(grant), .done_o(done), .fill_data_o(fill_data), .busy_o(busy),
        .m_re_o(m_re), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_rdata_i(m_rdata),
`ifdef MISS_CNT_EN
        .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt),
`endif
        .m_rdy_i(m_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: answers after mem_waits strobe cycles, logs what each completed op carried.
    int            mem_waits = 0;
    logic [LW-1:0] mem_rdata = '0;
    int            n_re = 0, n_we = 0, n_both = 0, wcnt = 0;
    logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [LW-1:0] last_wr_data = '0;

    assign m_rdata = mem_rdata;

    initial begin
        mdl_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mdl_rdy = 1'b0;
                wcnt    = 0;
            end else if (m_re || m_we) begin
                if (m_re) n_re++;
                if (m_we) n_we++;
                if (m_re && m_we) n_both++;
                if (wcnt >= mem_waits) begin
                    mdl_rdy = 1'b1;
                    wcnt    = 0;
                    if (m_re) last_rd_addr = m_addr;
                    if (m_we) begin
                        last_wr_addr = m_addr;
                        last_wr_data = m_wdata;
                    end
                end else begin
                    mdl_rdy = 1'b0;
                    wcnt++;
                end
            end else begin
                mdl_rdy = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // lat counts the request cycle itself, so a clean zero-wait miss reads 3.
    task automatic wait_done(output int lat);
        lat = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            lat++;
            if (done != '0) return;
        end
        lat = -1;
    endtask

    typedef struct {
        int            port;
        logic          wb;
        int            waits;
        logic [AW-1:0] vaddr;
        logic [AW-1:0] faddr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            exp_lat;
        int            exp_re;
        int            exp_we;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int            lat;
        int            base_re, base_we, base_both;
        logic [NP-1:0] oh;
        int            order[4];

        vecs[0] = '{0, 1'b0, 2, 14'h0000, 14'h0012, 64'h0, 64'hDEAD_C0DE_CAFE_BEEF, 5, 3, 0};
        vecs[1] = '{1, 1'b1, 0, 14'h0100, 14'h0200, 64'h1111_1111_1111_1111, 64'h2222_3333_4444_5555, 4, 1, 1};
        vecs[2] = '{0, 1'b1, 1, 14'h3FFF, 14'h0000, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0, 6, 2, 2};
        vecs[3] = '{1, 1'b0, 0, 14'h0000, 14'h1234, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 1, 0};

        rst = 1'b1; req = '0; wb_req = '0; victim = '0; fill = '0; wbdata = '0; stray_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_m_re", 64'(m_re), 64'h0);
        chk("rst_m_we", 64'(m_we), 64'h0);
        chk("rst_m_addr", 64'(m_addr), 64'h0);
        chk("rst_m_wdata", m_wdata, 64'h0);
        chk("rst_fill_data", fill_data, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            mem_waits = vecs[i].waits;
            mem_rdata = vecs[i].rdata;
            victim[vecs[i].port*AW +: AW] = vecs[i].vaddr;
            fill[vecs[i].port*AW +: AW]   = vecs[i].faddr;
            wbdata[vecs[i].port*LW +: LW] = vecs[i].wdata;
            wb_req[vecs[i].port] = vecs[i].wb;
            base_re = n_re; base_we = n_we; base_both = n_both;
            oh = '0;
            oh[vecs[i].port] = 1'b1;
            req[vecs[i].port] = 1'b1;
            wait_done(lat);
            chk("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
            chk("vec_done", 64'(done), 64'(oh));
            chk("vec_grant", 64'(grant), 64'(oh));
            chk("vec_fill_data", fill_data, vecs[i].rdata);
            req = '0; wb_req = '0;
            chk("vec_re_cycles", 64'(n_re - base_re), 64'(vecs[i].exp_re));
            chk("vec_we_cycles", 64'(n_we - base_we), 64'(vecs[i].exp_we));
            chk("vec_rd_addr", 64'(last_rd_addr), 64'(vecs[i].faddr));
            chk("vec_re_we_overlap", 64'(n_both - base_both), 64'h0);
            if (vecs[i].wb) begin
                chk("vec_wr_addr", 64'(last_wr_addr), 64'(vecs[i].vaddr));
                chk("vec_wr_data", last_wr_data, vecs[i].wdata);
            end
            @(negedge clk);
            chk("vec_done_one_cycle", 64'(done), 64'h0);
            repeat (2) @(negedge clk);
            chk("vec_idle_busy", 64'(busy), 64'h0);
        end

        // Rotation: after port0 is served and the mask has expired, port1 has priority.
        mem_waits = 0;
        req = 2'b01;
        wait_done(lat);
        chk("rr_first_done", 64'(done), 64'h1);
        req = '0;
        repeat (3) @(negedge clk);
        req = 2'b11;
        wait_done(lat);
        chk("rr_rotation", 64'(done), 64'h2);
        req[1] = 1'b0;
        wait_done(lat);
        chk("rr_then_port0", 64'(done), 64'h1);
        req = '0;
        repeat (3) @(negedge clk);

        // Contention from reset, both ports held.
        rst = 1'b1;
        req = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            wait_done(lat);
            order[n] = (done == 2'b10) ? 1 : (done == 2'b01) ? 0 : -1;
        end
        req = '0;
        chk("contend_0", 64'(order[0]), 64'd0);
        chk("contend_1", 64'(order[1]), 64'd1);
        chk("contend_2", 64'(order[2]), 64'd0);
        chk("contend_3", 64'(order[3]), 64'd1);
        repeat (3) @(negedge clk);

        // A port that keeps req up past its done is skipped for one IDLE cycle.
        req = 2'b01;
        wait_done(lat);
        chk("mask_first_done", 64'(done), 64'h1);
        repeat (2) @(negedge clk);
        chk("mask_cycle_no_grant", 64'(grant), 64'h0);
        @(negedge clk);
        chk("regrant_after_mask", 64'(grant), 64'h1);
        wait_done(lat);
        req = '0;
        repeat (3) @(negedge clk);

        // Reset during a writeback abandons it; the held request restarts from WB.
        mem_waits = 5;
        victim[AW +: AW] = 14'h0100; fill[AW +: AW] = 14'h0200;
        wbdata[LW +: LW] = 64'h1111_1111_1111_1111;
        wb_req = 2'b10; req = 2'b10;
        for (int c = 0; c < 10 && !m_we; c++) @(negedge clk);
        chk("rstwb_started", 64'(m_we), 64'h1);
        rst = 1'b1;
        #1;
        chk("rstwb_m_we", 64'(m_we), 64'h0);
        chk("rstwb_grant", 64'(grant), 64'h0);
        chk("rstwb_busy", 64'(busy), 64'h0);
        chk("rstwb_m_addr", 64'(m_addr), 64'h0);
        chk("rstwb_m_wdata", m_wdata, 64'h0);
        @(negedge clk);
        mem_waits = 0;
        base_we = n_we;
        rst = 1'b0;
        wait_done(lat);
        chk("rstwb_redone", 64'(done), 64'h2);
        chk("rstwb_relat", 64'(lat), 64'd4);
        chk("rstwb_rewrite", 64'(n_we - base_we), 64'd1);
        chk("rstwb_wr_addr", 64'(last_wr_addr), 64'h0100);
        req = '0; wb_req = '0;
        repeat (3) @(negedge clk);

        // Stray m_rdy while idle is ignored.
        stray_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stray_busy", 64'(busy), 64'h0);
            chk("stray_done", 64'(done), 64'h0);
        end
        stray_rdy = 1'b0;
        @(negedge clk);

        // Inputs changing under a granted fill leave the transaction untouched.
        mem_waits = 4;
        mem_rdata = 64'h7777_8888_9999_AAAA;
        fill[0 +: AW] = 14'h0AAA;
        req = 2'b01;
        @(negedge clk);
        fill[0 +: AW] = 14'h0BBB;
        req[1] = 1'b1;
        @(negedge clk);
        chk("hold_m_addr", 64'(m_addr), 64'h0AAA);
        chk("hold_grant", 64'(grant), 64'h1);
        req[1] = 1'b0;
        wait_done(lat);
        chk("hold_done", 64'(done), 64'h1);
        chk("hold_rd_addr", 64'(last_rd_addr), 64'h0AAA);
        chk("hold_fill_data", fill_data, 64'h7777_8888_9999_AAAA);
        req = '0;
        repeat (3) @(negedge clk);

`ifdef MISS_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_waits = 0;
        for (int n = 0; n < 5; n++) begin
            req = 2'b01;
            wait_done(lat);
            req = '0;
            repeat (3) @(negedge clk);
        end
        chk("cnt_miss_p0_sat", 64'(miss_cnt[0 +: CW]), 64'd3);
        chk("cnt_miss_p1", 64'(miss_cnt[CW +: CW]), 64'd0);
        chk("cnt_wb", 64'(wb_cnt), 64'd0);
        rst = 1'b1;
        #1;
        chk("cnt_rst", 64'(miss_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
